// File: rtl/alu_pkg.sv
// Shared ALU definitions: NZCV flag layout and the flags type used by the
// adder/subtractor and by downstream condition-check logic.
package alu_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [3:0] flags_t;

    // Assemble an NZCV vector from individual flag bits.
    function automatic flags_t pack_flags(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        flags_t f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit adder slice: one carry-chain chunk of the pipelined
// adder, also reporting whether its W-bit sum is all zeros.
module add_chunk #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         zero
);

    logic [W:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s       = total_s[W-1:0];
    assign cout    = total_s[W];
    assign zero    = ~|total_s[W-1:0];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor with NZCV flags and a valid/ready
// handshake. The carry chain is cut into STAGES chunks; stage k adds chunk k
// using the carry registered by stage k-1. Low result chunks already computed
// travel forward with the operation, and the operand chunks not yet added
// travel alongside as skew registers. One global stall freezes every stage.
module pipelined_add_sub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [3:0]       flags
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    // Keeps only the operand bits that later stages still have to add.
    function automatic logic [WIDTH-1:0] hi_mask(input int unsigned k);
        logic [WIDTH-1:0] m;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            m[i] = (i >= (k + 1) * CHUNK);
        end
        return m;
    endfunction

    // Values presented to each stage (entry stage: from the ports).
    logic [WIDTH-1:0] st_a_s     [STAGES];
    logic [WIDTH-1:0] st_b_s     [STAGES];
    logic [WIDTH-1:0] st_sum_s   [STAGES];
    logic             st_cin_s   [STAGES];
    logic             st_zero_s  [STAGES];
    logic             st_valid_s [STAGES];

    // Per-stage chunk adder results.
    logic [CHUNK-1:0] ch_sum_s   [STAGES];
    logic             ch_cout_s  [STAGES];
    logic             ch_zero_s  [STAGES];

    // Values each stage register will capture.
    logic [WIDTH-1:0] nx_a_s     [STAGES];
    logic [WIDTH-1:0] nx_b_s     [STAGES];
    logic [WIDTH-1:0] nx_sum_s   [STAGES];
    logic             nx_zero_s  [STAGES];

    // Stage registers; index LAST is the output stage.
    logic [WIDTH-1:0] a_r        [STAGES];
    logic [WIDTH-1:0] b_r        [STAGES];
    logic [WIDTH-1:0] sum_r      [STAGES];
    logic             carry_r    [STAGES];
    logic             zero_r     [STAGES];
    logic             valid_r    [STAGES];
    flags_t           flags_r;

    logic             advance_s;
    flags_t           flags_nx_s;
    logic             ovf_s;

    // The whole pipe moves unless a finished result is waiting on the consumer.
    assign advance_s = ~valid_r[LAST] | out_ready;
    assign in_ready  = advance_s;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_entry
                // Subtract is a + ~b + 1, so the carry-in port is overridden.
                assign st_a_s[k]     = a;
                assign st_b_s[k]     = sub ? ~b : b;
                assign st_cin_s[k]   = sub ? 1'b1 : c_in;
                assign st_sum_s[k]   = {WIDTH{1'b0}};
                assign st_zero_s[k]  = 1'b1;
                assign st_valid_s[k] = in_valid;
            end else begin : g_link
                assign st_a_s[k]     = a_r[k-1];
                assign st_b_s[k]     = b_r[k-1];
                assign st_cin_s[k]   = carry_r[k-1];
                assign st_sum_s[k]   = sum_r[k-1];
                assign st_zero_s[k]  = zero_r[k-1];
                assign st_valid_s[k] = valid_r[k-1];
            end

            add_chunk #(
                .W (CHUNK)
            ) u_add_chunk (
                .a    (st_a_s[k][k*CHUNK +: CHUNK]),
                .b    (st_b_s[k][k*CHUNK +: CHUNK]),
                .cin  (st_cin_s[k]),
                .s    (ch_sum_s[k]),
                .cout (ch_cout_s[k]),
                .zero (ch_zero_s[k])
            );
        end
    endgenerate

    // Merge each stage's chunk into the partial result and retire used operand bits.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            nx_sum_s[k]                  = st_sum_s[k];
            nx_sum_s[k][k*CHUNK +: CHUNK] = ch_sum_s[k];
            nx_a_s[k]                    = st_a_s[k] & hi_mask(k);
            nx_b_s[k]                    = st_b_s[k] & hi_mask(k);
            nx_zero_s[k]                 = st_zero_s[k] & ch_zero_s[k];
        end
    end

    // Signed overflow: operands of equal sign producing a result of the other sign.
    assign ovf_s = (st_a_s[LAST][WIDTH-1] == st_b_s[LAST][WIDTH-1]) &&
                   (ch_sum_s[LAST][CHUNK-1] != st_a_s[LAST][WIDTH-1]);

    assign flags_nx_s = pack_flags(ch_sum_s[LAST][CHUNK-1], nx_zero_s[LAST],
                                   ch_cout_s[LAST], ovf_s);

    // Pipeline registers: async clear, global hold on stall, data loads only for live ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_r[k]     <= {WIDTH{1'b0}};
                b_r[k]     <= {WIDTH{1'b0}};
                sum_r[k]   <= {WIDTH{1'b0}};
                carry_r[k] <= 1'b0;
                zero_r[k]  <= 1'b0;
                valid_r[k] <= 1'b0;
            end
            flags_r <= 4'b0000;
        end else if (advance_s) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_r[k] <= st_valid_s[k];
                if (st_valid_s[k]) begin
                    a_r[k]     <= nx_a_s[k];
                    b_r[k]     <= nx_b_s[k];
                    sum_r[k]   <= nx_sum_s[k];
                    carry_r[k] <= ch_cout_s[k];
                    zero_r[k]  <= nx_zero_s[k];
                end
            end
            if (st_valid_s[LAST]) begin
                flags_r <= flags_nx_s;
            end
        end
    end

    assign out_valid = valid_r[LAST];
    assign sum       = sum_r[LAST];
    assign c_out     = carry_r[LAST];
    assign flags     = flags_r;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed self-checking bench for pipelined_add_sub (WIDTH=64, STAGES=4).
module tb_pipelined_add_sub;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned STAGES = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic [3:0]       flags;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_add_sub #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .flags     (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op into an empty pipe and return cycles until out_valid is seen.
    task automatic run_op(input logic [63:0] va, input logic [63:0] vb,
                          input logic vc, input logic vs, output int lat);
        @(negedge clk);
        a = va; b = vb; c_in = vc; sub = vs;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] es;
        logic        ec;
        logic [3:0]  ef;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          lat;
        int          sent;
        int          recv;
        int          cycles;
        int          ghosts;
        logic        acc;
        logic        held;
        logic [63:0] held_sum;
        logic        held_cout;
        logic [3:0]  held_flags;
        logic [63:0] ei;
        logic [3:0]  ef;

        //                a                       b                       cin   sub   sum                     cout  NZCV
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                  1'b0, 1'b0, 64'h0,                  1'b1, 4'b0110};
        vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                  1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 4'b1001};
        vecs[2] = '{64'h5,                   64'h7,                  1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'b1000};
        vecs[3] = '{64'h7,                   64'h5,                  1'b0, 1'b1, 64'h2,                  1'b1, 4'b0010};
        vecs[4] = '{64'h0,                   64'h0,                  1'b1, 1'b0, 64'h1,                  1'b0, 4'b0000};
        vecs[5] = '{64'h5,                   64'h5,                  1'b1, 1'b1, 64'h0,                  1'b1, 4'b0110};
        vecs[6] = '{64'h0000_0000_FFFF_FFFF, 64'h1,                  1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 4'b0000};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'h1,                  1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'b0011};
        vecs[8] = '{64'h0001_0000_0000_0000, 64'hFFFF_0000_0000_0000, 1'b0, 1'b0, 64'h0,                  1'b1, 4'b0110};
        vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'b1010};

        // Reset with no clock edge yet.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 64'd0; b = 64'd0; c_in = 1'b0; sub = 1'b0;
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_c_out", {63'd0, c_out}, 64'd0);
        check("rst_flags", {60'd0, flags}, 64'd0);
        #1 rst = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed vectors, one at a time through an empty pipe.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(STAGES));
            check($sformatf("vec%0d_sum", i), sum, vecs[i].es);
            check($sformatf("vec%0d_c_out", i), {63'd0, c_out}, {63'd0, vecs[i].ec});
            check($sformatf("vec%0d_flags", i), {60'd0, flags}, {60'd0, vecs[i].ef});
        end
        @(negedge clk);

        // Back-to-back stream with out_ready toggling every cycle.
        sent = 0; recv = 0; cycles = 0; held = 1'b0;
        held_sum = 64'd0; held_cout = 1'b0; held_flags = 4'b0000;
        while (recv < 32 && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (held) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_sum", sum, held_sum);
                check("stall_c_out", {63'd0, c_out}, {63'd0, held_cout});
                check("stall_flags", {60'd0, flags}, {60'd0, held_flags});
            end
            out_ready = cycles[0];
            if (sent < 32) begin
                in_valid = 1'b1;
                a        = 64'(2 * sent);
                b        = 64'(sent) << 30;
                c_in     = sent[0];
                sub      = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                ei = 64'(2 * recv) + (64'(recv) << 30) + 64'(recv & 1);
                ef = {1'b0, (ei == 64'd0), 1'b0, 1'b0};
                check($sformatf("stream%0d_sum", recv), sum, ei);
                check($sformatf("stream%0d_flags", recv), {60'd0, flags}, {60'd0, ef});
                recv++;
            end
            held       = out_valid && !out_ready;
            held_sum   = sum;
            held_cout  = c_out;
            held_flags = flags;
            acc        = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
        end
        check("stream_count", 64'(recv), 64'd32);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        ghosts = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        check("stream_no_duplicates", 64'(ghosts), 64'd0);

        // Two ops in flight, first one stalled at the output, then reset mid-cycle.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; sub = 1'b0; c_in = 1'b0;
        a = 64'd100; b = 64'd1;
        @(negedge clk);
        a = 64'd200; b = 64'd2;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        check("pre_rst_sum", sum, 64'd101);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_sum", sum, 64'd0);
        check("mid_rst_flags", {60'd0, flags}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        ghosts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        check("post_rst_no_ghost", 64'(ghosts), 64'd0);
        run_op(64'd40, 64'd2, 1'b1, 1'b0, lat);
        check("post_rst_latency", 64'(lat), 64'(STAGES));
        check("post_rst_sum", sum, 64'd43);
        check("post_rst_flags", {60'd0, flags}, 64'd0);
        @(negedge clk);
        check("post_rst_drained", {63'd0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
